// File: rtl/ultrasonic_echo_emulator_if.sv
// ultrasonic_echo_emulator_if
//
// Purpose: bundles the ranging signals between a sensor controller and the
// ultrasonic echo emulator so that both sides share one port.
//
// Signals:
//   trigger      controller -> emulator  ranging request (asynchronous)
//   distance_cm  controller -> emulator  emulated target distance, 0 = no object
//   echo         emulator -> controller  echo pulse, width encodes distance
//   busy         emulator -> controller  high while a ranging is in progress
//   trig_err     emulator -> controller  one-cycle pulse on a rejected short trigger
//
// Modports:
//   master  the controller side (drives trigger and distance_cm)
//   slave   the emulator side (drives echo, busy and trig_err)
interface ultrasonic_echo_emulator_if;
    logic        trigger;
    logic [15:0] distance_cm;
    logic        echo;
    logic        busy;
    logic        trig_err;

    modport master (
        output trigger,
        output distance_cm,
        input  echo,
        input  busy,
        input  trig_err
    );

    modport slave (
        input  trigger,
        input  distance_cm,
        output echo,
        output busy,
        output trig_err
    );
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// ultrasonic_echo_emulator
//
// Purpose: behaves like an HC-SR04 style ultrasonic range sensor. A trigger
// pulse of at least MIN_TRIG_CYCLES starts a ranging: after ECHO_DELAY_CYCLES
// the echo output goes high for distance_cm * CYCLES_PER_CM cycles (clamped
// to MAX_ECHO_CYCLES, which is also used for "no object"), followed by a dead
// time of HOLDOFF_CYCLES during which new triggers are ignored.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   reset  synchronous, active-high reset
//   bus    ultrasonic_echo_emulator_if.slave (trigger, distance_cm in;
//          echo, busy, trig_err out)
//
// Optional feature: define ECHO_JITTER_EN to add 0..255 cycles of
// pseudo-random jitter (16-bit Fibonacci LFSR, seed 16'hACE1) to each echo
// width. Without the macro no LFSR is built.
module ultrasonic_echo_emulator #(
    parameter int MIN_TRIG_CYCLES   = 1000,
    parameter int ECHO_DELAY_CYCLES = 45000,
    parameter int CYCLES_PER_CM     = 5800,
    parameter int MAX_ECHO_CYCLES   = 3800000,
    parameter int HOLDOFF_CYCLES    = 1000000
) (
    input  logic                        clk,
    input  logic                        reset,
    ultrasonic_echo_emulator_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, TRIG, DELAY, ECHO, HOLDOFF} state_t;

    localparam logic [31:0] MIN_TRIG   = 32'(MIN_TRIG_CYCLES);
    localparam logic [31:0] DELAY_LAST = 32'(ECHO_DELAY_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST  = 32'(HOLDOFF_CYCLES - 1);
    localparam logic [32:0] MAX_ECHO   = 33'(MAX_ECHO_CYCLES);

    state_t      state;
    logic [31:0] count;
    logic        trig_m;
    logic        trig_s;
    logic        trig_d;
    logic        trig_rise;
    logic [15:0] dist_q;
    logic        echo_q;
    logic        busy_q;
    logic        err_q;
    logic [31:0] product;
    logic [32:0] raw_width;
    logic [31:0] echo_width;
    logic [31:0] echo_last;

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [7:0]  jit_q;
    logic        lfsr_fb;

    // Taps 16,14,13,11 of the Fibonacci LFSR (bit 15 is tap 16).
    assign lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign raw_width = {1'b0, product} + {25'd0, jit_q};
`else
    assign raw_width = {1'b0, product};
`endif

    // The width is derived from the latched distance, so changes on
    // distance_cm after the trigger is accepted never reach the pulse in flight.
    // Jitter is added before the clamp; the extra bit keeps the sum from wrapping.
    assign trig_rise  = trig_s & ~trig_d;
    assign product    = 32'(dist_q) * 32'(CYCLES_PER_CM);
    assign echo_width = (dist_q == 16'd0 || raw_width > MAX_ECHO) ?
                        MAX_ECHO[31:0] : raw_width[31:0];
    assign echo_last  = echo_width - 32'd1;

    // Synchronizer, edge detector and ranging FSM. The single counter is
    // cleared on every state change; echo, busy and trig_err are registered
    // and updated together with the state so they never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= 32'd0;
            trig_m <= 1'b0;
            trig_s <= 1'b0;
            trig_d <= 1'b0;
            dist_q <= 16'd0;
            echo_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
`ifdef ECHO_JITTER_EN
            lfsr   <= 16'hACE1;
            jit_q  <= 8'd0;
`endif
        end else begin
            trig_m <= bus.trigger;
            trig_s <= trig_m;
            trig_d <= trig_s;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig_rise) begin
                        state  <= TRIG;
                        count  <= 32'd1;
                        busy_q <= 1'b1;
                    end
                end
                TRIG: begin
                    if (trig_s) begin
                        if (count < MIN_TRIG) count <= count + 32'd1;
                    end else if (count >= MIN_TRIG) begin
                        state  <= DELAY;
                        count  <= 32'd0;
                        dist_q <= bus.distance_cm;
`ifdef ECHO_JITTER_EN
                        jit_q  <= lfsr[7:0];
                        lfsr   <= {lfsr[14:0], lfsr_fb};
`endif
                    end else begin
                        state  <= IDLE;
                        count  <= 32'd0;
                        busy_q <= 1'b0;
                        err_q  <= 1'b1;
                    end
                end
                DELAY: begin
                    if (count == DELAY_LAST) begin
                        state  <= ECHO;
                        count  <= 32'd0;
                        echo_q <= 1'b1;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                ECHO: begin
                    if (count == echo_last) begin
                        state  <= HOLDOFF;
                        count  <= 32'd0;
                        echo_q <= 1'b0;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                HOLDOFF: begin
                    if (count == HOLD_LAST) begin
                        state  <= IDLE;
                        count  <= 32'd0;
                        busy_q <= 1'b0;
                    end else begin
                        count <= count + 32'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= 32'd0;
                    echo_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.echo     = echo_q;
    assign bus.busy     = busy_q;
    assign bus.trig_err = err_q;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// tb_ultrasonic_echo_emulator
//
// Purpose: self-checking bench for ultrasonic_echo_emulator, run with scaled
// timing parameters so every scenario finishes in a few thousand cycles.
// Expected echo widths come from the distance rule (distance * cycles per cm,
// clamped, optional LFSR jitter). Expected delays are counted in clock edges
// from the cycle the raw trigger drops: two synchronizer edges, one FSM
// decision edge, then the programmed delay.
module tb_ultrasonic_echo_emulator;

    localparam int MIN   = 20;
    localparam int DLY   = 50;
    localparam int CPC   = 7;
    localparam int MAXW  = 700;
    localparam int HOLD  = 60;
    localparam int LIMIT = 5000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    bit   watch_busy = 1'b0;
    bit   busy_gap = 1'b0;
`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr_model = 16'hACE1;
`endif

    always #5 clk = ~clk;

    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .MIN_TRIG_CYCLES   (MIN),
        .ECHO_DELAY_CYCLES (DLY),
        .CYCLES_PER_CM     (CPC),
        .MAX_ECHO_CYCLES   (MAXW),
        .HOLDOFF_CYCLES    (HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Flags any cycle where busy is low while a ranging is expected to be active.
    always @(negedge clk) begin
        if (watch_busy && bus.busy !== 1'b1) busy_gap = 1'b1;
    end

    // Expected width of the next accepted ranging; consumes one jitter value.
    function automatic int expected_width(input int d);
        int w;
        int j;
        j = 0;
`ifdef ECHO_JITTER_EN
        j = int'(lfsr_model[7:0]);
        lfsr_model = {lfsr_model[14:0],
                      lfsr_model[15] ^ lfsr_model[13] ^ lfsr_model[12] ^ lfsr_model[10]};
`endif
        w = d * CPC + j;
        if (d == 0 || w > MAXW) w = MAXW;
        return w;
    endfunction

    task automatic model_reset();
`ifdef ECHO_JITTER_EN
        lfsr_model = 16'hACE1;
`endif
    endtask

    // Raw trigger high for exactly n clock cycles.
    task automatic drive_trigger(input int n);
        @(posedge clk);
        #1 bus.trigger = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.trigger = 1'b0;
    endtask

    // Clock edges until echo reaches level; -1 if the bound expires.
    task automatic wait_echo(input logic level, output int cnt);
        cnt = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.echo === level) begin
                cnt = i;
                return;
            end
        end
    endtask

    // Clock edges until busy drops; -1 if the bound expires.
    task automatic wait_idle(output int cnt);
        cnt = -1;
        for (int i = 1; i <= LIMIT; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.busy === 1'b0) begin
                cnt = i;
                return;
            end
        end
    endtask

    // One full ranging; distance_cm is scrambled during DELAY after it is latched.
    task automatic run_ranging(input int n_high, input int d, output int dly,
                               output int wid, output int hold, output bit gap);
        bus.distance_cm = 16'(d);
        drive_trigger(n_high);
        busy_gap   = 1'b0;
        watch_busy = 1'b1;
        fork
            wait_echo(1'b1, dly);
            begin
                repeat (6) @(posedge clk);
                #1 bus.distance_cm = 16'($urandom);
            end
        join
        wait_echo(1'b0, wid);
        watch_busy = 1'b0;
        gap = busy_gap;
        wait_idle(hold);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.trigger = 1'b0;
        bus.distance_cm = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.echo !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_echo got=%b want=0", bus.echo);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
        end
        checks++;
        if (bus.trig_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_trig_err got=%b want=0", bus.trig_err);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic check_ranging(input string name, input int n_high, input int d);
        int dly, wid, hold, exp_w;
        bit gap;
        exp_w = expected_width(d);
        run_ranging(n_high, d, dly, wid, hold, gap);
        checks++;
        if (dly !== DLY + 3) begin
            failures++;
            $display("[TB] FAIL %s_delay d=%0d got=%0d want=%0d", name, d, dly, DLY + 3);
        end
        checks++;
        if (wid !== exp_w) begin
            failures++;
            $display("[TB] FAIL %s_width d=%0d got=%0d want=%0d", name, d, wid, exp_w);
        end
        checks++;
        if (hold !== HOLD) begin
            failures++;
            $display("[TB] FAIL %s_holdoff d=%0d got=%0d want=%0d", name, d, hold, HOLD);
        end
        checks++;
        if (gap !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_busy_gap d=%0d got=%b want=0", name, d, gap);
        end
    endtask

    task automatic test_nominal();
        check_ranging("nominal", MIN, 10);
    endtask

    task automatic test_short_trigger();
        int lens [2];
        lens[0] = MIN - 1;
        lens[1] = 5;
        foreach (lens[k]) begin
            int errs, echos;
            logic busy_at_err;
            errs = 0;
            echos = 0;
            busy_at_err = 1'bx;
            bus.distance_cm = 16'd10;
            drive_trigger(lens[k]);
            repeat (12) begin
                @(negedge clk);
                if (bus.trig_err === 1'b1) begin
                    errs++;
                    busy_at_err = bus.busy;
                end
                if (bus.echo === 1'b1) echos++;
            end
            checks++;
            if (errs != 1) begin
                failures++;
                $display("[TB] FAIL short_err_pulses len=%0d got=%0d want=1", lens[k], errs);
            end
            checks++;
            if (busy_at_err !== 1'b0) begin
                failures++;
                $display("[TB] FAIL short_busy_at_err len=%0d got=%b want=0", lens[k], busy_at_err);
            end
            checks++;
            if (echos != 0) begin
                failures++;
                $display("[TB] FAIL short_echo len=%0d got=%0d want=0", lens[k], echos);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            check_ranging("random", MIN + int'($urandom_range(0, 40)),
                          int'($urandom_range(0, 130)));
        end
    endtask

    task automatic test_clamp();
        int ds [5];
        ds[0] = 0;
        ds[1] = 100;
        ds[2] = 101;
        ds[3] = 1000;
        ds[4] = 65535;
        foreach (ds[k]) check_ranging("clamp", MIN, ds[k]);
    endtask

    task automatic test_ignored();
        int dly, wid, hold, exp_w, stray;
        exp_w = expected_width(10);
        bus.distance_cm = 16'd10;
        drive_trigger(MIN);
        wait_echo(1'b1, dly);
        fork
            wait_echo(1'b0, wid);
            drive_trigger(MIN + 2);
        join
        checks++;
        if (wid !== exp_w) begin
            failures++;
            $display("[TB] FAIL ignored_echo_width got=%0d want=%0d", wid, exp_w);
        end
        fork
            wait_idle(hold);
            drive_trigger(MIN + 2);
        join
        checks++;
        if (hold !== HOLD) begin
            failures++;
            $display("[TB] FAIL ignored_holdoff got=%0d want=%0d", hold, HOLD);
        end
        // Trigger raised during HOLDOFF and still high when it ends.
        void'(expected_width(5));
        bus.distance_cm = 16'd5;
        drive_trigger(MIN);
        wait_echo(1'b1, dly);
        wait_echo(1'b0, wid);
        fork
            wait_idle(hold);
            begin
                repeat (10) @(posedge clk);
                #1 bus.trigger = 1'b1;
            end
        join
        stray = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("[TB] FAIL held_trigger_started got=%0d busy cycles want=0", stray);
        end
        @(posedge clk);
        #1 bus.trigger = 1'b0;
        repeat (3) @(posedge clk);
        check_ranging("after_ignored", MIN, 12);
    endtask

    task automatic test_reset_mid_echo();
        int dly, stray;
        void'(expected_width(20));
        bus.distance_cm = 16'd20;
        drive_trigger(MIN);
        wait_echo(1'b1, dly);
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (bus.echo !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midecho_reset echo=%b busy=%b want=0/0", bus.echo, bus.busy);
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.echo !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("[TB] FAIL midecho_residual got=%0d high cycles want=0", stray);
        end
        check_ranging("after_reset", MIN, 15);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_short_trigger();
        test_random();
        test_clamp();
        test_ignored();
        test_reset_mid_echo();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ultrasonic_echo_emulator.md
ULTRASONIC_ECHO_EMULATOR -- requirements
Module: ultrasonic_echo_emulator

Interface
REQ-001 SHALL have parameter MIN_TRIG_CYCLES, default 1000, minimum valid trigger high time in clk cycles (10 us at 100 MHz).
REQ-002 SHALL have parameter ECHO_DELAY_CYCLES, default 45000, cycles from trigger fall to echo rise (burst emulation).
REQ-003 SHALL have parameter CYCLES_PER_CM, default 5800, echo high cycles per cm of target distance (58 us/cm).
REQ-004 SHALL have parameter MAX_ECHO_CYCLES, default 3800000, echo width for no-object or out-of-range (38 ms).
REQ-005 SHALL have parameter HOLDOFF_CYCLES, default 1000000, dead time after echo before the next trigger is accepted.
REQ-006 clk  input  1  system clock, 100 MHz; all logic on posedge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 trigger  input  1  asynchronous ranging request from the controller.
REQ-009 distance_cm  input  16  emulated target distance, 0 = no object.
REQ-010 echo  output  1  emulated echo pulse, width encodes distance.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 trig_err  output  1  one-cycle pulse when a trigger shorter than MIN_TRIG_CYCLES is rejected.

Function
REQ-013 trigger SHALL pass through a 2-flop synchronizer; all timing below is referenced to the synchronized signal trig_s.
REQ-014 FSM states SHALL be IDLE, TRIG, DELAY, ECHO, HOLDOFF; one counter, 32 bits wide, shared across states, cleared on every state entry.
REQ-015 IDLE: on trig_s rising, go to TRIG with count 1.
REQ-016 TRIG: count increments while trig_s high, saturating at MIN_TRIG_CYCLES; on trig_s low, go to DELAY if count >= MIN_TRIG_CYCLES, else go to IDLE and pulse trig_err for exactly one cycle.
REQ-017 Trigger held high indefinitely SHALL keep the FSM in TRIG; no echo is produced until the falling edge.
REQ-018 distance_cm SHALL be latched on the cycle TRIG exits to DELAY; later changes do not affect the pulse in flight.
REQ-019 Echo width W = distance_cm * CYCLES_PER_CM computed at 32 bits; W = MAX_ECHO_CYCLES if distance_cm == 0 or the product > MAX_ECHO_CYCLES.
REQ-020 DELAY lasts exactly ECHO_DELAY_CYCLES cycles; echo SHALL be registered and rise on the first cycle of ECHO.
REQ-021 echo SHALL stay high exactly W cycles, then fall as the FSM enters HOLDOFF.
REQ-022 HOLDOFF lasts exactly HOLDOFF_CYCLES cycles, then returns to IDLE.
REQ-023 trig_s edges during DELAY, ECHO or HOLDOFF SHALL be ignored; a trigger already high on HOLDOFF exit SHALL NOT start a ranging (rising edge required).
REQ-024 echo and trig_err SHALL be glitch-free register outputs.

Reset
REQ-025 reset SHALL force FSM to IDLE, counter to 0, synchronizer flops to 0, latched distance to 0, echo = 0, busy = 0, trig_err = 0 on the next clk edge.
REQ-026 reset asserted mid-ECHO SHALL drop echo on the next edge with no residual pulse after release.

Configuration
REQ-027 Macro ECHO_JITTER_EN: when defined, W SHALL be increased by the low 8 bits (0..255) of a 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1), advanced once per accepted trigger, applied before the MAX_ECHO_CYCLES clamp.
REQ-028 Without ECHO_JITTER_EN, no LFSR SHALL be synthesized and W is exactly per REQ-019.

Verification
REQ-029 Trigger high 1000 cycles, distance_cm = 10 -> echo rises 45000 cycles after trig_s falls, high exactly 58000 cycles, busy high throughout.
REQ-030 Trigger high 500 cycles -> one-cycle trig_err, no echo, busy low within 1 cycle of trig_s fall.
REQ-031 distance_cm = 0, then distance_cm = 1000 -> echo width 3800000 cycles in both cases.
REQ-032 Second 1000-cycle trigger issued during ECHO and during HOLDOFF -> ignored; the next trigger after HOLDOFF produces a normal echo.
REQ-033 reset pulsed at cycle 20000 of ECHO -> echo = 0 next edge, FSM IDLE, new trigger then ranges normally.
REQ-034 With ECHO_JITTER_EN, 3 triggers at distance_cm = 10 -> widths 58000 + LFSR low byte from seed 16'hACE1 sequence, each in 58000..58255.
